// File: rtl/fps_pkg.sv
// rtl/fps_pkg.sv - shared constants, legal code ranges and FSM states for the front-panel selector config
package fps_pkg;

   localparam logic [7:0] ADDR_FPS1  = 8'd32;
   localparam logic [7:0] ADDR_FPS6  = 8'd37;
   localparam logic [7:0] ADDR_CTRL  = 8'd38;
   localparam logic [7:0] ADDR_STAT  = 8'd39;
   localparam logic [7:0] ADDR_DIRTY = 8'd40;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_MODE  = 1;
   localparam int CTRL_CLR   = 7;

   localparam int STAT_ARMED = 0;
   localparam int STAT_INV   = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_TMO   = 3;

   localparam logic [5:0] CODE_OFF = 6'h00;
   localparam logic [5:0] PG_LO    = 6'h0B;
   localparam logic [5:0] PG_HI    = 6'h18;
   localparam logic [5:0] DB_LO    = 6'h20;
   localparam logic [5:0] DB_HI    = 6'h27;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      APPLY
   } fps_state_e;

endpackage

// File: rtl/fps_code_check.sv
// rtl/fps_code_check.sv - combinational legality check of a 6-bit front-panel select code
module fps_code_check
   import fps_pkg::*;
(
   input  logic [5:0] i_code,
   output logic       o_legal
);

   assign o_legal = (i_code == CODE_OFF)
                 || ((i_code >= PG_LO) && (i_code <= PG_HI))
                 || ((i_code >= DB_LO) && (i_code <= DB_HI));

endmodule

// File: rtl/fps_cfg_ctrl.sv
// rtl/fps_cfg_ctrl.sv - shadow/active select registers with atomic commit, immediate or on an event code
module fps_cfg_ctrl
   import fps_pkg::*;
#(
   parameter logic [7:0]  COMMIT_CODE    = 8'h7D,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       event_valid,
   input  logic [7:0] event_code,
   output logic [5:0] FPS1,
   output logic [5:0] FPS2,
   output logic [5:0] FPS3,
   output logic [5:0] FPS4,
   output logic [5:0] FPS5,
   output logic [5:0] FPS6,
   output logic       armed,
   output logic       commit_done
);

   localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   fps_state_e       r_state, w_state_next;
   logic [5:0]       r_shadow [6];
   logic [5:0]       r_active [6];
   logic             r_mode;
   logic             r_err_inv, r_err_busy, r_timeout;
   logic             r_commit_done;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_rd_data, w_rd_mux;
   logic [5:0]       w_dirty;
   logic             w_legal, w_code_ok, w_sh_wr, w_ctrl_wr;
   logic             w_arm, w_clr, w_busy, w_match, w_expire, w_cnt_sat;

   fps_code_check u_code_check (
      .i_code  (wr_data[5:0]),
      .o_legal (w_legal)
   );

   assign w_code_ok = w_legal && (wr_data[7:6] == 2'b00);
   assign w_sh_wr   = wr_en && (wr_addr >= ADDR_FPS1) && (wr_addr <= ADDR_FPS6);
   assign w_ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
   assign w_arm     = w_ctrl_wr && wr_data[CTRL_ARM] && (r_state == IDLE);
   assign w_clr     = w_ctrl_wr && wr_data[CTRL_CLR];
   assign w_busy    = (r_state != IDLE);
   assign w_match   = event_valid && (event_code == COMMIT_CODE);
   assign w_cnt_sat = &r_cnt;
   // A matching event on the expiry cycle is handled first in the FSM, so it wins.
   assign w_expire  = (TIMEOUT_CYCLES != 0) && ((r_cnt + 1'b1) == CNT_LIMIT);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_arm) w_state_next = ARMED;
         ARMED: begin
            if (!r_mode || w_match) w_state_next = APPLY;
            else if (w_expire)      w_state_next = IDLE;
         end
         APPLY:   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 6; i++) w_dirty[i] = (r_shadow[i] != r_active[i]);
   end

   always_comb begin
      w_rd_mux = 8'h00;
      case (rd_addr)
         ADDR_STAT: begin
            w_rd_mux[STAT_ARMED] = w_busy;
            w_rd_mux[STAT_INV]   = r_err_inv;
            w_rd_mux[STAT_BUSY]  = r_err_busy;
            w_rd_mux[STAT_TMO]   = r_timeout;
         end
         ADDR_DIRTY: w_rd_mux = {2'b00, w_dirty};
         default: begin
            for (int i = 0; i < 6; i++)
               if (rd_addr == (ADDR_FPS1 + 8'(i))) w_rd_mux = {2'b00, r_shadow[i]};
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_mode        <= 1'b0;
         r_cnt         <= '0;
         r_err_inv     <= 1'b0;
         r_err_busy    <= 1'b0;
         r_timeout     <= 1'b0;
         r_commit_done <= 1'b0;
         r_rd_data     <= 8'h00;
         for (int i = 0; i < 6; i++) begin
            r_shadow[i] <= 6'h00;
            r_active[i] <= 6'h00;
         end
      end else begin
         r_state       <= w_state_next;
         r_rd_data     <= w_rd_mux;
         r_commit_done <= (r_state == APPLY);

         if (w_arm) begin
            r_mode <= wr_data[CTRL_MODE];
            r_cnt  <= '0;
         end else if ((r_state == ARMED) && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
         end

         for (int i = 0; i < 6; i++)
            if (w_sh_wr && !w_busy && w_code_ok && (wr_addr == (ADDR_FPS1 + 8'(i))))
               r_shadow[i] <= wr_data[5:0];

         if (r_state == APPLY)
            for (int i = 0; i < 6; i++) r_active[i] <= r_shadow[i];

         // Clear first so a status event in the same cycle still sticks.
         if (w_clr) begin
            r_err_inv  <= 1'b0;
            r_err_busy <= 1'b0;
            r_timeout  <= 1'b0;
         end
         if (w_sh_wr && w_busy)               r_err_busy <= 1'b1;
         if (w_sh_wr && !w_busy && !w_code_ok) r_err_inv <= 1'b1;
         if ((r_state == ARMED) && r_mode && !w_match && w_expire) r_timeout <= 1'b1;
      end
   end

   assign FPS1        = r_active[0];
   assign FPS2        = r_active[1];
   assign FPS3        = r_active[2];
   assign FPS4        = r_active[3];
   assign FPS5        = r_active[4];
   assign FPS6        = r_active[5];
   assign armed       = w_busy;
   assign commit_done = r_commit_done;
   assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_fps_cfg_ctrl.sv
// tb/tb_fps_cfg_ctrl.sv - directed self-checking bench for fps_cfg_ctrl
module tb_fps_cfg_ctrl;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       event_valid;
   logic [7:0] event_code;
   logic [5:0] FPS1, FPS2, FPS3, FPS4, FPS5, FPS6;
   logic       armed;
   logic       commit_done;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] rv;

   fps_cfg_ctrl #(
      .COMMIT_CODE    (8'h7D),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .event_valid (event_valid),
      .event_code  (event_code),
      .FPS1        (FPS1),
      .FPS2        (FPS2),
      .FPS3        (FPS3),
      .FPS4        (FPS4),
      .FPS5        (FPS5),
      .FPS6        (FPS6),
      .armed       (armed),
      .commit_done (commit_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      rd_addr = a;
      tick();
      d = rd_data;
   endtask

   task automatic send_event(input logic [7:0] code);
      event_valid = 1'b1; event_code = code;
      tick();
      event_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      rd_addr = 8'h00; event_valid = 1'b0; event_code = 8'h00;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // reset state
      for (int a = 32; a <= 40; a++) begin
         rd(8'(a), rv);
         chk($sformatf("reset_rd_%0d", a), rv, 8'h00);
      end
      chk("reset_fps1", {2'b0, FPS1}, 8'h00);
      chk("reset_fps6", {2'b0, FPS6}, 8'h00);
      chk("reset_armed", {7'b0, armed}, 8'h00);
      chk("reset_done", {7'b0, commit_done}, 8'h00);

      // immediate commit
      wr(8'd32, 8'h0B);
      wr(8'd37, 8'h27);
      rd(8'd32, rv); chk("shadow32", rv, 8'h0B);
      rd(8'd40, rv); chk("dirty_pre", rv, 8'h21);
      wr(8'd38, 8'h01);
      chk("imm_armed_n", {7'b0, armed}, 8'h01);
      chk("imm_fps1_n", {2'b0, FPS1}, 8'h00);
      tick();
      chk("imm_armed_n1", {7'b0, armed}, 8'h01);
      chk("imm_fps1_n1", {2'b0, FPS1}, 8'h00);
      chk("imm_done_n1", {7'b0, commit_done}, 8'h00);
      tick();
      chk("imm_fps1_n2", {2'b0, FPS1}, 8'h0B);
      chk("imm_fps6_n2", {2'b0, FPS6}, 8'h27);
      chk("imm_done_n2", {7'b0, commit_done}, 8'h01);
      chk("imm_armed_n2", {7'b0, armed}, 8'h00);
      tick();
      chk("imm_done_n3", {7'b0, commit_done}, 8'h00);
      rd(8'd40, rv); chk("dirty_post", rv, 8'h00);

      // illegal codes and status clear
      wr(8'd33, 8'h19);
      rd(8'd33, rv); chk("inv_19", rv, 8'h00);
      wr(8'd33, 8'h3F);
      rd(8'd33, rv); chk("inv_3f", rv, 8'h00);
      rd(8'd39, rv); chk("stat_inv", rv, 8'h02);
      wr(8'd38, 8'h80);
      rd(8'd39, rv); chk("stat_clr", rv, 8'h00);
      wr(8'd33, 8'h18);
      rd(8'd33, rv); chk("legal_18", rv, 8'h18);
      wr(8'd33, 8'h0A);
      rd(8'd33, rv); chk("inv_0a", rv, 8'h18);
      wr(8'd33, 8'h40);
      rd(8'd33, rv); chk("inv_40", rv, 8'h18);
      wr(8'd38, 8'h80);

      // event commit with busy write while armed
      wr(8'd38, 8'h03);
      send_event(8'h7C);
      chk("ev_armed_7c", {7'b0, armed}, 8'h01);
      chk("ev_fps2_7c", {2'b0, FPS2}, 8'h00);
      wr(8'd34, 8'h20);
      rd(8'd34, rv); chk("busy_shadow", rv, 8'h00);
      rd(8'd39, rv); chk("stat_busy", rv, 8'h05);
      send_event(8'h7D);
      chk("ev_fps2_e", {2'b0, FPS2}, 8'h00);
      chk("ev_armed_e", {7'b0, armed}, 8'h01);
      tick();
      chk("ev_fps2_e1", {2'b0, FPS2}, 8'h18);
      chk("ev_done_e1", {7'b0, commit_done}, 8'h01);
      wr(8'd38, 8'h80);

      // timeout with no events
      wr(8'd35, 8'h0C);
      wr(8'd38, 8'h03);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk($sformatf("tmo_armed_%0d", i), {7'b0, armed}, 8'h01);
      end
      tick();
      chk("tmo_armed_8", {7'b0, armed}, 8'h00);
      chk("tmo_fps4", {2'b0, FPS4}, 8'h00);
      tick();
      chk("tmo_done", {7'b0, commit_done}, 8'h00);
      rd(8'd39, rv); chk("stat_tmo", rv, 8'h08);
      rd(8'd40, rv); chk("dirty_tmo", rv, 8'h08);
      wr(8'd38, 8'h80);
      rd(8'd39, rv); chk("stat_tmo_clr", rv, 8'h00);

      // matching event on the expiry cycle wins
      wr(8'd38, 8'h03);
      repeat (7) tick();
      send_event(8'h7D);
      chk("race_armed", {7'b0, armed}, 8'h01);
      chk("race_fps4_e", {2'b0, FPS4}, 8'h00);
      tick();
      chk("race_fps4_e1", {2'b0, FPS4}, 8'h0C);
      chk("race_done", {7'b0, commit_done}, 8'h01);
      rd(8'd39, rv); chk("race_stat", rv, 8'h00);

      // reset while armed drops the pending commit
      wr(8'd36, 8'h21);
      wr(8'd38, 8'h03);
      chk("rst_pre_armed", {7'b0, armed}, 8'h01);
      rst_n = 1'b0;
      #1;
      chk("rst_armed", {7'b0, armed}, 8'h00);
      chk("rst_fps1", {2'b0, FPS1}, 8'h00);
      chk("rst_fps4", {2'b0, FPS4}, 8'h00);
      tick();
      rst_n = 1'b1;
      send_event(8'h7D);
      tick();
      tick();
      chk("post_rst_armed", {7'b0, armed}, 8'h00);
      chk("post_rst_done", {7'b0, commit_done}, 8'h00);
      chk("post_rst_fps5", {2'b0, FPS5}, 8'h00);
      rd(8'd36, rv); chk("post_rst_shadow", rv, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fps_cfg_ctrl.md
# fps_cfg_ctrl

Configuration controller for the front-panel output selector. Holds a host-writable shadow copy of the six front-panel select codes (reg32–reg37) and transfers it atomically to the active FPS1..FPS6 outputs, either immediately or on a chosen event code, so all six outputs switch on the same clock edge. It sits between the host register bus and the front-panel mapping mux, and drives that mux's six select inputs.

## Interface
Parameters:
- COMMIT_CODE, 8'h7D: event code that triggers a commit in event mode.
- TIMEOUT_CYCLES, 1_000_000: clocks to wait in ARMED before abort; 0 disables the timeout.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host write strobe, one cycle per write.
- wr_addr  in  8  host write address.
- wr_data  in  8  host write data.
- rd_addr  in  8  host read address.
- rd_data  out  8  registered read data.
- event_valid  in  1  event_code is valid this cycle.
- event_code  in  8  received event code.
- FPS1..FPS6  out  6 each  active select codes to the front-panel mux.
- armed  out  1  high while a commit is pending.
- commit_done  out  1  one-cycle pulse when the active set is updated.

## Operation
- Register map:
  - 32–37: shadow select for FPS1..FPS6. Writes update the shadow; reads return the shadow.
  - 38: control, write-only. bit0 = arm, bit1 = mode (0 immediate, 1 event), bit7 = clear status.
  - 39: status. bit0 = armed, bit1 = err_invalid, bit2 = err_busy, bit3 = timeout.
  - 40: dirty mask. bits5:0, bit i = shadow(i) != active(i).
  - Any other address reads 0; writes to it are ignored.
- Legal codes are 0x00 (off), 0x0B–0x18 (pulse generators 0–13) and 0x20–0x27 (distributed bus bits 0–7).
  - A write of any other code leaves the shadow unchanged and sets err_invalid.
- Shadow writes while ARMED are rejected: the shadow is unchanged and err_busy is set.
- FSM:
  - IDLE: an arm write latches the mode and moves to ARMED. The timeout counter clears.
  - ARMED, immediate mode: moves to APPLY on the next cycle.
  - ARMED, event mode: moves to APPLY on event_valid && event_code == COMMIT_CODE. Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES (if nonzero), the state returns to IDLE and timeout is set.
  - APPLY: active <= shadow (all six together), commit_done = 1, then IDLE.
- Status bits are sticky and cleared only by a control write with bit7 = 1.
- Simultaneous events:
  - An arm write while ARMED or APPLY is ignored. It does not restart the counter and sets no error.
  - Clear and arm in the same write: both take effect.
  - Matching event in the same cycle as timeout expiry: the event wins and the commit proceeds.
  - An invalid write and a busy write in the same cycle cannot both occur. If the state is ARMED, busy has priority.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset values: FPS1..FPS6 = 0, shadow = 0, rd_data = 0, armed = 0, commit_done = 0, status = 0, FSM = IDLE.
  - Reset mid-ARMED drops the pending commit.
- A shadow write at edge N is visible in a read, and in the dirty mask, from N+1.
- rd_data is registered: rd_addr sampled at edge N appears after edge N, i.e. 1-cycle read latency.
- Immediate commit: arm write at edge N → ARMED after N → APPLY after N+1 → FPS outputs and commit_done change at edge N+2.
- Event commit: match sampled at edge E → APPLY after E → FPS outputs update at E+1, with commit_done high for that one cycle.
- armed is high exactly while the FSM is in ARMED or APPLY.
- FPS outputs change only on the APPLY edge and never glitch between commits.

## Structure
- Shared package fps_pkg contains:
  - address constants 32–40 and the control/status bit positions;
  - the legal-code ranges;
  - the FSM state enum (IDLE, ARMED, APPLY).
- One sub-module, fps_code_check: a combinational 6-bit legality check, instantiated once on wr_data[5:0] with wr_data[7:6] == 0 also required.
- Everything else (shadow file, active registers, FSM, counter, read mux) lives in fps_cfg_ctrl.

## Test plan
- Reset, then read 32–40 → all 0. FPS1..FPS6 = 0.
- Write 32 = 0x0B, 37 = 0x27, then arm with mode 0 → dirty reads 0x21 before the commit. FPS1 = 0x0B and FPS6 = 0x27 appear at arm edge + 2, with a one-cycle commit_done pulse. Dirty then reads 0.
- Write 33 = 0x19, then 33 = 0x3F → shadow stays 0 and status bit1 = 1. A write of 0x80 to 38 clears it to 0.
- Arm in event mode: send event 0x7C (no change), then 0x7D → outputs update one edge after the 0x7D edge. A shadow write during ARMED sets err_busy and leaves the shadow unchanged.
- Use TIMEOUT_CYCLES = 8 and arm in event mode with no events → return to IDLE after 8 cycles, timeout = 1, outputs unchanged. Repeat with 0x7D on the expiry cycle → the commit happens and timeout stays 0.
- Assert rst_n low while ARMED → outputs 0, armed = 0. No commit follows after release, even when 0x7D arrives.
